// File: rtl/stw_pkg.sv
// stw_pkg: shared types and helpers for the stationary-weight self-test.
//   stw_state_t    - tester FSM states
//   STW_LFSR_TAPS  - 16-bit Galois LFSR tap mask (taps 16,14,13,11)
//   stw_lfsr_next  - one Galois LFSR step
//   stw_expected   - golden partial sum for a row: (row+1)*w*a mod 2^word_size
package stw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        APPLY,
        WAIT,
        CHECK,
        DONE
    } stw_state_t;

    localparam logic [15:0] STW_LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] stw_lfsr_next(input logic [15:0] s);
        logic [15:0] shifted;
        shifted = {1'b0, s[15:1]};
        return s[0] ? (shifted ^ STW_LFSR_TAPS) : shifted;
    endfunction

    // w and a arrive as word_size-bit two's-complement values, zero-extended.
    // Modular arithmetic makes the unsigned product equal to the signed one.
    function automatic logic [63:0] stw_expected(input int unsigned row,
                                                 input logic [63:0]  w,
                                                 input logic [63:0]  a,
                                                 input int unsigned  word_size);
        logic [63:0] mask;
        logic [63:0] prod;
        mask = (word_size >= 64) ? '1 : ((64'd1 << word_size) - 64'd1);
        prod = ((w & mask) * (a & mask)) & mask;
        return (64'(row + 1) * prod) & mask;
    endfunction

endpackage

// File: rtl/stw_pattern_lfsr.sv
// stw_pattern_lfsr: 16-bit Galois LFSR supplying STW test patterns.
//   clk      in   clock
//   rst      in   synchronous active-high reset; loads seed
//   seed     in   16-bit reset value (must be nonzero)
//   advance  in   step once this cycle (caller gates it with !stall)
//   lfsr_out out  current LFSR state
module stw_pattern_lfsr
    import stw_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [15:0] lfsr_out
);

    logic [15:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= seed;
        end else if (advance) begin
            lfsr_q <= stw_lfsr_next(lfsr_q);
        end
    end

    assign lfsr_out = lfsr_q;

endmodule

// File: rtl/stw_column_tester.sv
// stw_column_tester: stationary-weight self-test for one systolic-array column.
// Loads an LFSR-derived weight into every PE, injects an LFSR-derived
// activation, waits SAMPLE_DELAY cycles and compares each row's psum with
// (row+1)*w*a. Failing rows are cleared (sticky) in stw_result_mat.
//   clk, rst        clock, synchronous active-high reset
//   start           single-cycle run request (ignored while busy)
//   stall           global stall: freezes FSM/counters/LFSR, gates strobes
//   pe_psum_flat    per-row PE bottom outputs, row r at [r*WORD_SIZE +: WORD_SIZE]
//   inject_mask     (STW_FAULT_INJECT_EN only) flip psum bit 0 of masked rows
//   stw_mode        test path select
//   stw_load        weight load strobe
//   stw_apply       activation inject strobe
//   stw_weight      test weight
//   stw_left_in     test activation
//   stw_result_mat  per-row pass vector (1 = pass)
//   stw_complete    run finished, results valid
//   busy            run in progress
// Optional feature macro: STW_FAULT_INJECT_EN. WORD_SIZE must be even and <= 16.
module stw_column_tester
    import stw_pkg::*;
#(
    parameter int unsigned ROWS         = 4,
    parameter int unsigned COL_IDX      = 0,
    parameter int unsigned WORD_SIZE    = 16,
    parameter int unsigned NUM_PATTERNS = 8,
    parameter int unsigned SAMPLE_DELAY = 6,
    parameter logic [15:0] SEED         = 16'hACE1
)
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stall,
    input  logic [ROWS*WORD_SIZE-1:0] pe_psum_flat,
`ifdef STW_FAULT_INJECT_EN
    input  logic [ROWS-1:0]           inject_mask,
`endif
    output logic                      stw_mode,
    output logic                      stw_load,
    output logic                      stw_apply,
    output logic [WORD_SIZE-1:0]      stw_weight,
    output logic [WORD_SIZE-1:0]      stw_left_in,
    output logic [ROWS-1:0]           stw_result_mat,
    output logic                      stw_complete,
    output logic                      busy
);

    localparam int unsigned       HALF     = WORD_SIZE / 2;
    localparam int unsigned       DLY_W    = (SAMPLE_DELAY > 1) ? $clog2(SAMPLE_DELAY) : 1;
    localparam logic [DLY_W-1:0]  DLY_INIT = DLY_W'(SAMPLE_DELAY - 1);
    localparam logic [7:0]        LAST_PAT = 8'(NUM_PATTERNS - 1);
    localparam logic [15:0]       SEED_EFF = SEED ^ 16'(COL_IDX);

    stw_state_t           state_q;
    logic [7:0]           pat_q;
    logic [DLY_W-1:0]     dly_q;
    logic [WORD_SIZE-1:0] weight_q;
    logic [WORD_SIZE-1:0] left_q;
    logic [ROWS-1:0]      result_q;
    logic [ROWS-1:0]      result_d;
    logic                 complete_q;
    logic                 busy_q;
    logic                 mode_q;

    logic [15:0]          lfsr_q;
    logic [15:0]          lfsr_d;
    logic                 lfsr_adv;
    logic [WORD_SIZE-1:0] lfsr_now_w;
    logic [WORD_SIZE-1:0] lfsr_nxt_w;

    function automatic logic [WORD_SIZE-1:0] sext_half(input logic [HALF-1:0] h);
        return {{(WORD_SIZE - HALF){h[HALF-1]}}, h};
    endfunction

    assign lfsr_adv   = (state_q == CHECK) && !stall;
    assign lfsr_d     = stw_lfsr_next(lfsr_q);
    assign lfsr_now_w = lfsr_q[WORD_SIZE-1:0];
    assign lfsr_nxt_w = lfsr_d[WORD_SIZE-1:0];

    stw_pattern_lfsr u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .seed     (SEED_EFF),
        .advance  (lfsr_adv),
        .lfsr_out (lfsr_q)
    );

    // Per-row comparison against the golden value, folded into the sticky vector.
    always_comb begin
        logic [WORD_SIZE-1:0] row_psum;
        logic [63:0]          exp_full;
        result_d = result_q;
        row_psum = '0;
        exp_full = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            row_psum = pe_psum_flat[r*WORD_SIZE +: WORD_SIZE];
`ifdef STW_FAULT_INJECT_EN
            row_psum[0] = row_psum[0] ^ inject_mask[r];
`endif
            exp_full = stw_expected(r, 64'(weight_q), 64'(left_q), WORD_SIZE);
            if (64'(row_psum) != exp_full) begin
                result_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pat_q      <= '0;
            dly_q      <= '0;
            weight_q   <= '0;
            left_q     <= '0;
            result_q   <= '1;
            complete_q <= 1'b0;
            busy_q     <= 1'b0;
            mode_q     <= 1'b0;
        end else if (!stall) begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        result_q   <= '1;
                        complete_q <= 1'b0;
                        busy_q     <= 1'b1;
                        mode_q     <= 1'b1;
                        pat_q      <= '0;
                        weight_q   <= sext_half(lfsr_now_w[HALF-1:0]);
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    left_q  <= sext_half(lfsr_now_w[WORD_SIZE-1:HALF]);
                    state_q <= APPLY;
                end
                APPLY: begin
                    dly_q   <= DLY_INIT;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (dly_q == '0) begin
                        state_q <= CHECK;
                    end else begin
                        dly_q <= dly_q - 1'b1;
                    end
                end
                CHECK: begin
                    result_q <= result_d;
                    pat_q    <= pat_q + 8'd1;
                    if (pat_q == LAST_PAT) begin
                        complete_q <= 1'b1;
                        busy_q     <= 1'b0;
                        mode_q     <= 1'b0;
                        state_q    <= DONE;
                    end else begin
                        // Weight must be valid during the LOAD strobe, so it is taken
                        // from the LFSR value that this same edge advances to.
                        weight_q <= sext_half(lfsr_nxt_w[HALF-1:0]);
                        state_q  <= LOAD;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stw_load       = (state_q == LOAD)  && !stall;
    assign stw_apply      = (state_q == APPLY) && !stall;
    assign stw_mode       = mode_q;
    assign stw_weight     = weight_q;
    assign stw_left_in    = left_q;
    assign stw_result_mat = result_q;
    assign stw_complete   = complete_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_stw_column_tester.sv
// Scoreboard bench for stw_column_tester with an ideal column model.
module tb_stw_column_tester;

    localparam int ROWS = 4;
    localparam int WS   = 16;

    logic              clk   = 1'b0;
    logic              rst   = 1'b1;
    logic              start = 1'b0;
    logic              stall = 1'b0;
    logic [ROWS*WS-1:0] pe_psum_flat;
`ifdef STW_FAULT_INJECT_EN
    logic [ROWS-1:0]   inject_mask = '0;
`endif
    logic              stw_mode, stw_load, stw_apply, stw_complete, busy;
    logic [WS-1:0]     stw_weight, stw_left_in;
    logic [ROWS-1:0]   stw_result_mat;

    stw_column_tester #(
        .ROWS         (4),
        .COL_IDX      (0),
        .WORD_SIZE    (16),
        .NUM_PATTERNS (8),
        .SAMPLE_DELAY (6),
        .SEED         (16'hACE1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .stall          (stall),
        .pe_psum_flat   (pe_psum_flat),
`ifdef STW_FAULT_INJECT_EN
        .inject_mask    (inject_mask),
`endif
        .stw_mode       (stw_mode),
        .stw_load       (stw_load),
        .stw_apply      (stw_apply),
        .stw_weight     (stw_weight),
        .stw_left_in    (stw_left_in),
        .stw_result_mat (stw_result_mat),
        .stw_complete   (stw_complete),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] res;
        int         at;
    } done_t;

    done_t       done_q[$];
    logic [15:0] wq[$];
    logic [15:0] aq[$];
    logic [15:0] model_s = 16'hACE1;
    int          n_load  = 0;
    int          n_apply = 0;
    logic        fault_r2 = 1'b0;

    // Ideal column: latch weight/activation on strobes, psum_r = (r+1)*w*a.
    logic [15:0] col_w = '0;
    logic [15:0] col_a = '0;
    always @(posedge clk) begin
        if (stw_load)  col_w <= stw_weight;
        if (stw_apply) col_a <= stw_left_in;
    end
    always_comb begin
        logic [15:0] v;
        v = '0;
        pe_psum_flat = '0;
        for (int r = 0; r < ROWS; r++) begin
            v = 16'(r + 1) * col_w * col_a;
            if (fault_r2 && r == 2) v[3] = 1'b0;
            pe_psum_flat[r*WS +: WS] = v;
        end
    end

    function automatic logic [15:0] model_next(input logic [15:0] s);
        logic [15:0] n;
        n = {1'b0, s[15:1]};
        if (s[0]) begin
            n[15] = ~n[15];
            n[13] = ~n[13];
            n[12] = ~n[12];
            n[10] = ~n[10];
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event with nothing expected (cycle %0d)", name, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the 8 patterns and the completion for a run started this cycle.
    task automatic push_run(input logic [3:0] res, input int lat);
        done_t d;
        for (int i = 0; i < 8; i++) begin
            wq.push_back({{8{model_s[7]}}, model_s[7:0]});
            aq.push_back({{8{model_s[15]}}, model_s[15:8]});
            model_s = model_next(model_s);
        end
        d.res = res;
        d.at  = cyc + lat;
        done_q.push_back(d);
    endtask

    task automatic wait_complete(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (stw_complete) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL completion_timeout: got no stw_complete expected one within %0d cycles", budget);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_result"},   32'(stw_result_mat), 32'hF);
        chk({tag, "_complete"}, 32'(stw_complete),   32'h0);
        chk({tag, "_busy"},     32'(busy),           32'h0);
        chk({tag, "_mode"},     32'(stw_mode),       32'h0);
        chk({tag, "_load"},     32'(stw_load),       32'h0);
        chk({tag, "_apply"},    32'(stw_apply),      32'h0);
        chk({tag, "_weight"},   32'(stw_weight),     32'h0);
        chk({tag, "_left_in"},  32'(stw_left_in),    32'h0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a strobe or completion.
    initial begin
        logic  prev_c;
        done_t d;
        prev_c = 1'b0;
        forever begin
            @(negedge clk);
            if (stw_load) begin
                n_load++;
                if (wq.size() == 0) fail("weight_unexpected");
                else chk("weight", 32'(stw_weight), 32'(wq.pop_front()));
            end
            if (stw_apply) begin
                n_apply++;
                if (aq.size() == 0) fail("left_in_unexpected");
                else chk("left_in", 32'(stw_left_in), 32'(aq.pop_front()));
            end
            if (stw_complete && !prev_c) begin
                if (done_q.size() == 0) begin
                    fail("complete_unexpected");
                end else begin
                    d = done_q.pop_front();
                    chk("result_mat",    32'(stw_result_mat), 32'(d.res));
                    chk("complete_time", 32'(cyc),            32'(d.at));
                    chk("busy_at_done",  32'(busy),           32'h0);
                    chk("mode_at_done",  32'(stw_mode),       32'h0);
                end
            end
            prev_c = stw_complete;
        end
    end

    initial begin
        int l0, a0;

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_reset_vals("reset");

        // Fault-free run with start pulses while busy
        push_run(4'b1111, 73);
        start = 1'b1; tick(); start = 1'b0;
        repeat (10) tick();
        chk("busy_midrun", 32'(busy),     32'h1);
        chk("mode_midrun", 32'(stw_mode), 32'h1);
        start = 1'b1; tick(); start = 1'b0;
        repeat (20) tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_complete(200);

        // Row 2 psum bit 3 stuck at 0
        fault_r2 = 1'b1;
        push_run(4'b1011, 73);
        start = 1'b1; tick(); start = 1'b0;
        wait_complete(200);
        tick();
        fault_r2 = 1'b0;

        // Start from DONE clears results; 5-cycle stall in WAIT of pattern 3
        l0 = n_load;
        a0 = n_apply;
        push_run(4'b1111, 78);
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_complete", 32'(stw_complete),   32'h0);
        chk("restart_result",   32'(stw_result_mat), 32'hF);
        repeat (29) tick();
        stall = 1'b1;
        repeat (5) tick();
        stall = 1'b0;
        wait_complete(200);
        tick();
        chk("load_pulses",  32'(n_load - l0),  32'd8);
        chk("apply_pulses", 32'(n_apply - a0), 32'd8);

        // Reset in WAIT of pattern 4
        push_run(4'b1111, 73);
        start = 1'b1; tick(); start = 1'b0;
        repeat (38) tick();
        rst = 1'b1;
        tick();
        check_reset_vals("midrun_reset");
        rst = 1'b0;
        wq.delete();
        aq.delete();
        done_q.delete();
        model_s = 16'hACE1;
        tick();

        // Fresh run after reset replays the sequence from the seed
        push_run(4'b1111, 73);
        start = 1'b1; tick(); start = 1'b0;
        chk("first_load_strobe", 32'(stw_load),   32'h1);
        chk("first_weight",      32'(stw_weight), 32'hFFE1);
        wait_complete(200);
        tick();

`ifdef STW_FAULT_INJECT_EN
        inject_mask = 4'b0001;
        push_run(4'b1110, 73);
        start = 1'b1; tick(); start = 1'b0;
        wait_complete(200);
        tick();
        inject_mask = '0;
`endif

        repeat (3) tick();
        chk("pending_completions", 32'(done_q.size()), 32'd0);
        chk("pending_weights",     32'(wq.size()),     32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
